// File: rtl/mux_display_capture_if.sv
// Bundle between the scanned 7-segment bus and the decoded frame outputs.
// Optional total/total_ok signals exist only when BINARY_TOTAL_EN is defined.
interface mux_display_capture_if;
   logic [6:0] seg;
   logic [2:0] an_n;
   logic       err_clr;
   logic [3:0] dig_h;
   logic [3:0] dig_t;
   logic [3:0] dig_u;
   logic       frame_valid;
   logic       seg_err;
   logic       an_err;
   logic       link_lost;
`ifdef BINARY_TOTAL_EN
   logic [9:0] total;
   logic       total_ok;

   modport master (output seg, an_n, err_clr,
                   input  dig_h, dig_t, dig_u, frame_valid, seg_err, an_err, link_lost,
                          total, total_ok);
   modport slave  (input  seg, an_n, err_clr,
                   output dig_h, dig_t, dig_u, frame_valid, seg_err, an_err, link_lost,
                          total, total_ok);
`else
   modport master (output seg, an_n, err_clr,
                   input  dig_h, dig_t, dig_u, frame_valid, seg_err, an_err, link_lost);
   modport slave  (input  seg, an_n, err_clr,
                   output dig_h, dig_t, dig_u, frame_valid, seg_err, an_err, link_lost);
`endif
endinterface

// File: rtl/mux_display_capture.sv
// Captures a multiplexed 3-digit 7-segment scan, decodes it and publishes whole frames.
// Define BINARY_TOTAL_EN to add the binary total/total_ok outputs.
module mux_display_capture #(
   parameter int STABLE_CYC  = 8,
   parameter int TIMEOUT_CYC = 200000,
   parameter int CNT_W       = 18
) (
   input logic                  clk,
   input logic                  rst_n,
   mux_display_capture_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_MAX  = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [6:0]       seg_s1, seg_s2;
   logic [2:0]       an_s1, an_s2, an_prev;
   logic             clr_s1, clr_s2;
   state_t           state, state_next;
   logic             stab_clr, stab_inc, capture;
   logic [CNT_W-1:0] stab_cnt, tcnt;
   logic [2:0]       slot_cap, seen, seen_next;
   logic             blank_cap, an_bad, cap_any, timeout_hit;
   logic [3:0]       code;
   logic [3:0]       sh_h, sh_t, sh_u;
   logic [3:0]       dig_h, dig_t, dig_u;
   logic             frame_valid, seg_err, an_err, link_lost;

   function automatic logic [3:0] decode_seg(input logic [6:0] s);
      case (s)
         7'b0111111: return 4'h0;
         7'b0000110: return 4'h1;
         7'b1011011: return 4'h2;
         7'b1001111: return 4'h3;
         7'b1100110: return 4'h4;
         7'b1101101: return 4'h5;
         7'b1111101: return 4'h6;
         7'b0000111: return 4'h7;
         7'b1111111: return 4'h8;
         7'b1101111: return 4'h9;
         7'b1111001: return 4'hE;
         7'b1010000: return 4'hF;
         7'b0000000: return 4'hB;
         default:    return 4'hC;
      endcase
   endfunction

   // Two-flop synchronisers; an_prev lets us see a change of the synchronised enables
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1  <= 7'd0;
         seg_s2  <= 7'd0;
         an_s1   <= 3'b111;
         an_s2   <= 3'b111;
         an_prev <= 3'b111;
         clr_s1  <= 1'b0;
         clr_s2  <= 1'b0;
      end else begin
         seg_s1  <= bus.seg;
         seg_s2  <= seg_s1;
         an_s1   <= bus.an_n;
         an_s2   <= an_s1;
         an_prev <= an_s2;
         clr_s1  <= bus.err_clr;
         clr_s2  <= clr_s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         stab_cnt <= '0;
      end else begin
         state <= state_next;
         if (stab_clr)
            stab_cnt <= '0;
         else if (stab_inc)
            stab_cnt <= stab_cnt + 1'b1;
      end
   end

   // One capture per dwell, taken on the cycle the stability count completes
   always_comb begin
      state_next = state;
      stab_clr   = 1'b0;
      stab_inc   = 1'b0;
      capture    = 1'b0;
      unique case (state)
         IDLE: begin
            state_next = SETTLE;
            stab_clr   = 1'b1;
         end
         SETTLE: begin
            if (an_s2 != an_prev) begin
               stab_clr = 1'b1;
            end else if (stab_cnt == STABLE_LAST) begin
               capture    = 1'b1;
               state_next = HELD;
            end else begin
               stab_inc = 1'b1;
            end
         end
         HELD: begin
            if (an_s2 != an_prev) begin
               state_next = SETTLE;
               stab_clr   = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      slot_cap  = 3'b000;
      blank_cap = 1'b0;
      an_bad    = 1'b0;
      if (capture) begin
         case (an_s2)
            3'b011:  slot_cap = 3'b100;
            3'b101:  slot_cap = 3'b010;
            3'b110:  slot_cap = 3'b001;
            3'b111:  blank_cap = 1'b1;
            default: an_bad = 1'b1;
         endcase
      end
   end

   assign code        = decode_seg(seg_s2);
   assign cap_any     = (|slot_cap) | blank_cap;
   assign timeout_hit = !cap_any && (tcnt == TIMEOUT_LAST);

   // A capture landing on the frame-copy cycle is ORed in after the clear so it survives
   always_comb begin
      seen_next = seen;
      if (seen == 3'b111 || timeout_hit)
         seen_next = 3'b000;
      seen_next = seen_next | slot_cap;
   end

`ifdef BINARY_TOTAL_EN
   logic [9:0] total_sum, total;
   logic       total_digits_ok, total_ok;

   assign total_digits_ok = (sh_h <= 4'd9) && (sh_t <= 4'd9) && (sh_u <= 4'd9);
   assign total_sum = (10'(sh_h) << 6) + (10'(sh_h) << 5) + (10'(sh_h) << 2)
                    + (10'(sh_t) << 3) + (10'(sh_t) << 1) + 10'(sh_u);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_h        <= 4'hB;
         sh_t        <= 4'hB;
         sh_u        <= 4'hB;
         seen        <= 3'b000;
         dig_h       <= 4'hB;
         dig_t       <= 4'hB;
         dig_u       <= 4'hB;
         frame_valid <= 1'b0;
         tcnt        <= '0;
         link_lost   <= 1'b0;
         seg_err     <= 1'b0;
         an_err      <= 1'b0;
`ifdef BINARY_TOTAL_EN
         total       <= 10'd0;
         total_ok    <= 1'b0;
`endif
      end else begin
         if (slot_cap[2]) sh_h <= code;
         if (slot_cap[1]) sh_t <= code;
         if (slot_cap[0]) sh_u <= code;
         seen        <= seen_next;
         frame_valid <= (seen == 3'b111);
         if (seen == 3'b111) begin
            dig_h <= sh_h;
            dig_t <= sh_t;
            dig_u <= sh_u;
`ifdef BINARY_TOTAL_EN
            total    <= total_digits_ok ? total_sum : 10'd0;
            total_ok <= total_digits_ok;
`endif
         end
         if (cap_any) begin
            tcnt      <= '0;
            link_lost <= 1'b0;
         end else if (tcnt != TIMEOUT_MAX) begin
            tcnt <= tcnt + 1'b1;
            if (timeout_hit)
               link_lost <= 1'b1;
         end
         seg_err <= ((|slot_cap) && (code == 4'hC)) || (seg_err && !clr_s2);
         an_err  <= an_bad || (an_err && !clr_s2);
      end
   end

   assign bus.dig_h       = dig_h;
   assign bus.dig_t       = dig_t;
   assign bus.dig_u       = dig_u;
   assign bus.frame_valid = frame_valid;
   assign bus.seg_err     = seg_err;
   assign bus.an_err      = an_err;
   assign bus.link_lost   = link_lost;
`ifdef BINARY_TOTAL_EN
   assign bus.total       = total;
   assign bus.total_ok    = total_ok;
`endif

endmodule

// File: tb/tb_mux_display_capture.sv
// Directed bench for mux_display_capture: frames go through an expectation queue,
// status flags are checked inline at hand-computed cycles.
module tb_mux_display_capture;

   localparam int STABLE = 8;
   localparam int TMO    = 300;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux_display_capture_if bus ();

   mux_display_capture #(
      .STABLE_CYC (STABLE),
      .TIMEOUT_CYC(TMO),
      .CNT_W      (18)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic [3:0] h;
      logic [3:0] t;
      logic [3:0] u;
      logic [9:0] tot;
      logic       ok;
   } frame_t;

   frame_t expq[$];
   int vectors = 0;
   int miscompares = 0;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] an, input logic [6:0] s, input int ncyc);
      @(negedge clk);
      bus.an_n = an;
      bus.seg  = s;
      repeat (ncyc) @(posedge clk);
   endtask

   task automatic pushFrame(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                            input logic [9:0] tot, input logic ok);
      frame_t f;
      f.h = h; f.t = t; f.u = u; f.tot = tot; f.ok = ok;
      expq.push_back(f);
   endtask

   // Frame monitor: every frame_valid pulse must match the oldest expected frame
   always @(negedge clk) begin
      if (rst_n && bus.frame_valid) begin
         if (expq.size() == 0) begin
            checkOutput("unexpected_frame", 16'd1, 16'd0);
         end else begin : pop_blk
            frame_t e;
            e = expq.pop_front();
            checkOutput("frame_dig_h", 16'(bus.dig_h), 16'(e.h));
            checkOutput("frame_dig_t", 16'(bus.dig_t), 16'(e.t));
            checkOutput("frame_dig_u", 16'(bus.dig_u), 16'(e.u));
`ifdef BINARY_TOTAL_EN
            checkOutput("frame_total", 16'(bus.total), 16'(e.tot));
            checkOutput("frame_total_ok", 16'(bus.total_ok), 16'(e.ok));
`endif
         end
      end
   end

   initial begin
      bus.an_n    = 3'b111;
      bus.seg     = 7'd0;
      bus.err_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_dig_h", 16'(bus.dig_h), 16'hB);
      checkOutput("reset_dig_t", 16'(bus.dig_t), 16'hB);
      checkOutput("reset_dig_u", 16'(bus.dig_u), 16'hB);
      checkOutput("reset_frame_valid", 16'(bus.frame_valid), 16'd0);
      checkOutput("reset_seg_err", 16'(bus.seg_err), 16'd0);
      checkOutput("reset_an_err", 16'(bus.an_err), 16'd0);
      checkOutput("reset_link_lost", 16'(bus.link_lost), 16'd0);
`ifdef BINARY_TOTAL_EN
      checkOutput("reset_total", 16'(bus.total), 16'd0);
      checkOutput("reset_total_ok", 16'(bus.total_ok), 16'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Normal scan "053", two rounds -> two frames
      pushFrame(4'h0, 4'h5, 4'h3, 10'd53, 1'b1);
      pushFrame(4'h0, 4'h5, 4'h3, 10'd53, 1'b1);
      for (int r = 0; r < 2; r++) begin
         applyStimulus(3'b011, 7'b0111111, 20);
         applyStimulus(3'b101, 7'b1101101, 20);
         applyStimulus(3'b110, 7'b1001111, 20);
      end

      // Overflow display "rrE"
      pushFrame(4'hF, 4'hF, 4'hE, 10'd0, 1'b0);
      applyStimulus(3'b011, 7'b1010000, 20);
      applyStimulus(3'b101, 7'b1010000, 20);
      applyStimulus(3'b110, 7'b1111001, 20);

      // Glitchy enables with an '8' on the bus; any stray capture would corrupt the next frame
      for (int i = 0; i < 17; i++)
         applyStimulus((i % 2 == 0) ? 3'b011 : 3'b101, 7'b1111111, 3);
      pushFrame(4'h1, 4'h2, 4'h7, 10'd127, 1'b1);
      applyStimulus(3'b110, 7'b0000111, 20);
      applyStimulus(3'b011, 7'b0000110, 20);
      applyStimulus(3'b101, 7'b1011011, 20);

      // Illegal segment pattern in the hundreds slot
      pushFrame(4'hC, 4'h9, 4'h4, 10'd0, 1'b0);
      applyStimulus(3'b011, 7'b0001000, 20);
      applyStimulus(3'b101, 7'b1101111, 20);
      applyStimulus(3'b110, 7'b1100110, 20);
      #1;
      checkOutput("seg_err_set", 16'(bus.seg_err), 16'd1);
      checkOutput("an_err_still_clear", 16'(bus.an_err), 16'd0);
      applyStimulus(3'b001, 7'd0, 10);
      applyStimulus(3'b111, 7'd0, 5);
      #1;
      checkOutput("an_err_set", 16'(bus.an_err), 16'd1);
      checkOutput("seg_err_sticky", 16'(bus.seg_err), 16'd1);
      @(negedge clk);
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("seg_err_cleared", 16'(bus.seg_err), 16'd0);
      checkOutput("an_err_cleared", 16'(bus.an_err), 16'd0);
      repeat (10) @(posedge clk);

      // Timeout: hundreds captured 11 edges after the drive, link_lost TMO edges later
      @(negedge clk);
      bus.an_n = 3'b011;
      bus.seg  = 7'b1111101;
      repeat (STABLE + 2 + TMO) @(posedge clk);
      #1;
      checkOutput("link_lost_before_timeout", 16'(bus.link_lost), 16'd0);
      @(posedge clk);
      #1;
      checkOutput("link_lost_at_timeout", 16'(bus.link_lost), 16'd1);
      checkOutput("hold_dig_h", 16'(bus.dig_h), 16'hC);
      checkOutput("hold_dig_t", 16'(bus.dig_t), 16'h9);
      checkOutput("hold_dig_u", 16'(bus.dig_u), 16'h4);
      // Resume; the hundreds captured before the timeout must not count toward this frame
      pushFrame(4'h1, 4'h3, 4'h8, 10'd138, 1'b1);
      applyStimulus(3'b101, 7'b1001111, 12);
      #1;
      checkOutput("link_lost_cleared", 16'(bus.link_lost), 16'd0);
      repeat (8) @(posedge clk);
      applyStimulus(3'b110, 7'b1111111, 20);
      applyStimulus(3'b011, 7'b0000110, 20);
      applyStimulus(3'b111, 7'd0, 20);

      // Reset after hundreds and tens captures (tens illegal so seg_err is up)
      applyStimulus(3'b011, 7'b1011011, 20);
      applyStimulus(3'b101, 7'b0001000, 20);
      applyStimulus(3'b110, 7'b0000111, 5);
      #1;
      checkOutput("pre_reset_seg_err", 16'(bus.seg_err), 16'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_dig_h", 16'(bus.dig_h), 16'hB);
      checkOutput("midreset_dig_t", 16'(bus.dig_t), 16'hB);
      checkOutput("midreset_dig_u", 16'(bus.dig_u), 16'hB);
      checkOutput("midreset_seg_err", 16'(bus.seg_err), 16'd0);
      checkOutput("midreset_link_lost", 16'(bus.link_lost), 16'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pushFrame(4'h9, 4'h0, 4'h7, 10'd907, 1'b1);
      applyStimulus(3'b110, 7'b0000111, 20);
      applyStimulus(3'b011, 7'b1101111, 20);
      applyStimulus(3'b101, 7'b0111111, 20);
      applyStimulus(3'b111, 7'd0, 20);

      checkOutput("frames_outstanding", 16'(expq.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
